// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU round-robin sequencer.
// Provides operand width, opcode encodings, FSM state type and an
// illegal-opcode helper.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB    = 3'b001;
  localparam logic [OP_W-1:0] OP_AND    = 3'b010;
  localparam logic [OP_W-1:0] OP_OR     = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR    = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT    = 3'b101;
  // Opcodes from OP_ILL_LO upward (110, 111) are illegal.
  localparam logic [OP_W-1:0] OP_ILL_LO = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op >= OP_ILL_LO);
  endfunction

endpackage

// File: rtl/alu4.sv
// Shared combinational 4-bit ALU.
// Ports: op (opcode), a/b (operands) -> result, slt, zero, carry, ovf.
// carry/ovf are meaningful for ADD/SUB only; slt is set only by SLT.
// Illegal opcodes give result 0 (zero=1); callers mask flags themselves.
module alu4
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              slt,
  output logic              zero,
  output logic              carry,
  output logic              ovf
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    slt    = 1'b0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
        ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: begin
        slt    = ($signed(a) < $signed(b));
        result = DATA_W'(slt);
      end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// Ports: req_valid (per-requester), last_grant (previous winner)
//        -> gnt_valid_c (any request), gnt_id_c (winner index).
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       gnt_valid_c,
  output logic       gnt_id_c
);

  always_comb begin
    gnt_valid_c = |req_valid;
    gnt_id_c    = 1'b0;
    case (req_valid)
      2'b10:   gnt_id_c = 1'b1;
      2'b11:   gnt_id_c = ~last_grant;   // contention: the one not served last
      default: gnt_id_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALU between two requesters with round-robin arbitration.
// Ports: clk, rst_n; req_valid/req_ready per requester with reqN_op/a/b;
//        resp_valid/resp_ready response channel carrying resp_id,
//        resp_result, resp_slt/zero/carry/ovf, resp_err; busy; op_count.
// Flow: IDLE (accept) -> EXEC (ALU outputs registered) -> RESP (hold).
module alu_rr_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_slt,
  output logic              resp_zero,
  output logic              resp_carry,
  output logic              resp_ovf,
  output logic              resp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  state_t            state_next;
  logic              gnt_valid;
  logic              gnt_id;
  logic              accept;
  logic              last_grant;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_slt;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_ovf;
  logic              illegal;

  rr_arbiter2 u_arb (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .gnt_valid_c (gnt_valid),
    .gnt_id_c    (gnt_id)
  );

  alu4 u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .slt    (alu_slt),
    .zero   (alu_zero),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  assign illegal = op_is_illegal(op_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and accept strobe; req_ready is only ever raised in IDLE.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_valid) begin
          req_ready  = 2'(2'b01 << gnt_id);
          accept     = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: state_next = S_RESP;
      S_RESP: if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch, registered response, status and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_grant  <= 1'b1;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_slt    <= 1'b0;
      resp_zero   <= 1'b0;
      resp_carry  <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
      op_count    <= '0;
    end else begin
      if (accept) begin
        op_q       <= gnt_id ? req1_op : req0_op;
        a_q        <= gnt_id ? req1_a  : req0_a;
        b_q        <= gnt_id ? req1_b  : req0_b;
        id_q       <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == S_EXEC) begin
        // Illegal opcodes report err with result and every flag cleared.
        resp_id     <= id_q;
        resp_result <= illegal ? '0 : alu_result;
        resp_slt    <= ~illegal & alu_slt;
        resp_zero   <= ~illegal & alu_zero;
        resp_carry  <= ~illegal & alu_carry;
        resp_ovf    <= ~illegal & alu_ovf;
        resp_err    <= illegal;
      end
      if (state == S_RESP && resp_ready) op_count <= op_count + CNT_W'(1);
      resp_valid <= (state_next == S_RESP);
      busy       <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: stimulus pushes hand-computed
// expected responses into a queue; a monitor pops and compares on every
// response handshake.
module tb_alu_rr_sequencer;
  import alu_pkg::*;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic       id;
    logic [3:0] result;
    logic       slt;
    logic       zero;
    logic       carry;
    logic       ovf;
    logic       err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              resp_valid, resp_ready, resp_id;
  logic [DATA_W-1:0] resp_result;
  logic              resp_slt, resp_zero, resp_carry, resp_ovf, resp_err;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  exp_t exp_q[$];
  exp_t exp_m;
  int   checks = 0;
  int   errors = 0;
  int   resp_seen = 0;

  always #5 clk = ~clk;

  alu_rr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_slt(resp_slt), .resp_zero(resp_zero),
    .resp_carry(resp_carry), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .busy(busy), .op_count(op_count)
  );

  function automatic exp_t mk(input logic id, input logic [3:0] res,
                              input logic slt, input logic zero,
                              input logic carry, input logic ovf,
                              input logic err);
    return {id, res, slt, zero, carry, ovf, err};
  endfunction

  function automatic exp_t cur_resp();
    return {resp_id, resp_result, resp_slt, resp_zero, resp_carry, resp_ovf, resp_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare each presented response at the edge it will be taken.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=0x%0h required=none", cur_resp());
      end else begin
        exp_m = exp_q.pop_front();
        check("resp_fields", 32'(cur_resp()), 32'(exp_m));
      end
      resp_seen++;
    end
  end

  task automatic do_reset(input string tag);
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    rst_n      = 1'b0;
    #1;
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_resp_result"}, resp_result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present one request and wait for its acceptance; operands are
  // scrambled afterwards to show they were latched on the accept edge.
  task automatic send(input int id, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_op = op; req1_a = a; req1_b = b; end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        if (id == 0) begin req0_a = ~a; req0_b = ~b; end
        else         begin req1_a = ~a; req1_b = ~b; end
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept id=%0d", id);
      req_valid[id] = 1'b0;
    end
  endtask

  task automatic wait_seen(input int target);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      if (resp_seen >= target) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=%0d required=%0d", resp_seen, target);
    end
  endtask

  initial begin
    int  w;
    int  base;
    bit  found;
    rst_n = 1'b0;
    req_valid = 2'b00; resp_ready = 1'b1;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;

    // 1: single ADD with carry-out and zero result.
    do_reset("rst1");
    base = resp_seen;
    exp_q.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    send(0, OP_ADD, 4'hF, 4'h1, w);
    check("add_ready_first_cycle", w, 0);
    @(negedge clk);
    check("add_lat_exec_valid", resp_valid, 0);
    check("add_lat_exec_busy", busy, 1);
    @(negedge clk);
    check("add_lat_resp_valid", resp_valid, 1);
    wait_seen(base + 1);
    check("add_op_count", op_count, 1);

    // 2: both valid right after reset; requester 0 first, no accept while busy.
    do_reset("rst2");
    base = resp_seen;
    exp_q.push_back(mk(1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    req0_op = OP_SUB; req0_a = 4'h3; req0_b = 4'hA;
    req1_op = OP_SLT; req1_a = 4'h9; req1_b = 4'h2;
    req_valid = 2'b11;
    @(negedge clk);
    check("rr_first_grant", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
      else check("no_accept_while_busy", req_ready, 2'b00);
    end
    check("busy_drops", found, 1);
    check("rr_second_grant", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_seen(base + 2);
    check("two_ops_count", op_count, 2);

    // 3: fairness with both continuously valid.
    do_reset("rst3");
    base = resp_seen;
    exp_q.push_back(mk(1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    req0_op = OP_AND; req0_a = 4'hC; req0_b = 4'hA;
    req1_op = OP_OR;  req1_a = 4'hC; req1_b = 4'h3;
    req_valid = 2'b11;
    wait_seen(base + 4);
    req_valid = 2'b00;
    check("fair_op_count", op_count, 4);

    // 4: backpressure in RESP, with requester 0 waiting meanwhile.
    base = resp_seen;
    resp_ready = 1'b0;
    exp_q.push_back(mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    send(1, OP_XOR, 4'h5, 4'h6, w);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (resp_valid) found = 1'b1;
    end
    check("bp_resp_arrives", found, 1);
    req0_op = OP_ADD; req0_a = 4'h7; req0_b = 4'h1;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_hold", 32'(cur_resp()), 32'(mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
      check("bp_valid_hold", resp_valid, 1);
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", req_ready, 2'b01);
    check("bp_one_handshake", op_count, 5);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_seen(base + 2);

    // 5: illegal opcode from requester 1.
    base = resp_seen;
    exp_q.push_back(mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(1, 3'b110, 4'h3, 4'h4, w);
    @(negedge clk);
    check("ill_lat_exec_valid", resp_valid, 0);
    @(negedge clk);
    check("ill_lat_resp_valid", resp_valid, 1);
    wait_seen(base + 1);
    check("ill_op_count", op_count, 7);

    // 6: reset during EXEC discards the op; then requester 0 wins first.
    send(1, OP_ADD, 4'h2, 4'h3, w);
    do_reset("rst_exec");
    base = resp_seen;
    exp_q.push_back(mk(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    req0_op = OP_OR;  req0_a = 4'h1; req0_b = 4'h2;
    req1_op = OP_SUB; req1_a = 4'h5; req1_b = 4'h5;
    req_valid = 2'b11;
    @(negedge clk);
    check("post_rst_grant", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    send(1, OP_SUB, 4'h5, 4'h5, w);
    wait_seen(base + 2);
    check("post_rst_count", op_count, 2);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
